// File: rtl/alu_issue_arbiter_pkg.sv
// Shared ALU definitions for the issue arbiter: data width, RISC-V funct3 op codes
// and the requester port index type.
package alu_issue_arbiter_pkg;

  localparam int unsigned ALU_DATA_W = 32;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SLL  = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SRL  = 3'b101;
  localparam logic [2:0] ALU_OR   = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b111;

  typedef logic [0:0] port_idx_t;

  localparam port_idx_t PORT0 = 1'b0;
  localparam port_idx_t PORT1 = 1'b1;

endpackage

// File: rtl/alu_issue_arbiter_rsp.sv
// First-word-fall-through response FIFO carrying ALU result and tag, with an
// occupancy count used by the issue credit logic.
module alu_rsp_fifo
  import alu_issue_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAG_W = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ALU_DATA_W-1:0] wr_result,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic                  rd_en,
  output logic                  rd_valid,
  output logic [ALU_DATA_W-1:0] rd_result,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [CNT_W-1:0]      count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SLOTS = 1 << PTR_W;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [ALU_DATA_W-1:0] result_q [SLOTS];
  logic [TAG_W-1:0]      tag_q    [SLOTS];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  do_pop;

  assign do_pop = rd_en && (count_q != '0);

  // Storage needs no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      result_q[wr_ptr_q] <= wr_result;
      tag_q[wr_ptr_q]    <= wr_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end
      if (wr_en && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (!wr_en && do_pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  assign rd_valid  = (count_q != '0);
  assign rd_result = result_q[rd_ptr_q];
  assign rd_tag    = tag_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/alu_issue_arbiter.sv
// Two-port issue arbiter for a shared 1-cycle registered ALU, with credit-based flow
// control into per-port response FIFOs.
module alu_issue_arbiter
  import alu_issue_arbiter_pkg::*;
#(
  parameter int unsigned TAG_W      = 4,
  parameter int unsigned RSP_DEPTH  = 2,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_valid,
  output logic                  p0_ready,
  input  logic [ALU_DATA_W-1:0] p0_a,
  input  logic [ALU_DATA_W-1:0] p0_b,
  input  logic [2:0]            p0_op,
  input  logic                  p0_aux,
  input  logic [TAG_W-1:0]      p0_tag,
  output logic                  p0_rsp_valid,
  input  logic                  p0_rsp_ready,
  output logic [ALU_DATA_W-1:0] p0_rsp_result,
  output logic [TAG_W-1:0]      p0_rsp_tag,
  input  logic                  p1_valid,
  output logic                  p1_ready,
  input  logic [ALU_DATA_W-1:0] p1_a,
  input  logic [ALU_DATA_W-1:0] p1_b,
  input  logic [2:0]            p1_op,
  input  logic                  p1_aux,
  input  logic [TAG_W-1:0]      p1_tag,
  output logic                  p1_rsp_valid,
  input  logic                  p1_rsp_ready,
  output logic [ALU_DATA_W-1:0] p1_rsp_result,
  output logic [TAG_W-1:0]      p1_rsp_tag,
  output logic [ALU_DATA_W-1:0] alu_a,
  output logic [ALU_DATA_W-1:0] alu_b,
  output logic [2:0]            alu_op,
  output logic                  alu_aux,
  input  logic [ALU_DATA_W-1:0] alu_result
);

  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int unsigned CRD_W = CNT_W + 1;

  logic [CNT_W-1:0] count0, count1;
  logic             fifo_valid0, fifo_valid1;
  logic             pop0, pop1;
  logic             push0, push1;
  logic [CRD_W-1:0] credit0, credit1;
  logic             elig0, elig1;
  logic             grant0, grant1;
  logic             blocked;

  logic             s1_valid_q;
  port_idx_t        s1_port_q;
  logic [TAG_W-1:0] s1_tag_q;
  port_idx_t        last_q;
  logic             hold_q;

  // Issue is held off during reset and on the first cycle after it.
  assign blocked = rst || hold_q;

  assign p0_rsp_valid = fifo_valid0 && !rst;
  assign p1_rsp_valid = fifo_valid1 && !rst;
  assign pop0 = p0_rsp_valid && p0_rsp_ready;
  assign pop1 = p1_rsp_valid && p1_rsp_ready;

  assign push0 = s1_valid_q && (s1_port_q == PORT0);
  assign push1 = s1_valid_q && (s1_port_q == PORT1);

  always_comb begin
    credit0 = CRD_W'(count0) + CRD_W'(push0);
    credit1 = CRD_W'(count1) + CRD_W'(push1);
    // A same-cycle pop frees the slot the new op will eventually land in.
    elig0 = p0_valid && !blocked && ((credit0 < CRD_W'(RSP_DEPTH)) || pop0);
    elig1 = p1_valid && !blocked && ((credit1 < CRD_W'(RSP_DEPTH)) || pop1);
  end

  always_comb begin
    grant0  = 1'b0;
    grant1  = 1'b0;
    alu_a   = '0;
    alu_b   = '0;
    alu_op  = '0;
    alu_aux = 1'b0;
    if (FIXED_PRIO != 0) begin
      grant0 = elig0;
      grant1 = elig1 && !elig0;
    end else if (elig0 && elig1) begin
      grant0 = (last_q == PORT1);
      grant1 = (last_q == PORT0);
    end else begin
      grant0 = elig0;
      grant1 = elig1;
    end
    if (grant0) begin
      alu_a   = p0_a;
      alu_b   = p0_b;
      alu_op  = p0_op;
      alu_aux = p0_aux;
    end else if (grant1) begin
      alu_a   = p1_a;
      alu_b   = p1_b;
      alu_op  = p1_op;
      alu_aux = p1_aux;
    end
  end

  assign p0_ready = grant0;
  assign p1_ready = grant1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_port_q  <= PORT0;
      s1_tag_q   <= '0;
      last_q     <= PORT1;
      hold_q     <= 1'b1;
    end else begin
      hold_q     <= 1'b0;
      s1_valid_q <= grant0 || grant1;
      if (grant0 || grant1) begin
        s1_port_q <= grant1 ? PORT1 : PORT0;
        s1_tag_q  <= grant1 ? p1_tag : p0_tag;
        last_q    <= grant1 ? PORT1 : PORT0;
      end
    end
  end

  alu_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .TAG_W (TAG_W)
  ) u_fifo0 (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (push0),
    .wr_result (alu_result),
    .wr_tag    (s1_tag_q),
    .rd_en     (pop0),
    .rd_valid  (fifo_valid0),
    .rd_result (p0_rsp_result),
    .rd_tag    (p0_rsp_tag),
    .count     (count0)
  );

  alu_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .TAG_W (TAG_W)
  ) u_fifo1 (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (push1),
    .wr_result (alu_result),
    .wr_tag    (s1_tag_q),
    .rd_en     (pop1),
    .rd_valid  (fifo_valid1),
    .rd_result (p1_rsp_result),
    .rd_tag    (p1_rsp_tag),
    .count     (count1)
  );

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based
// model of credits, arbitration, latency and ordering.
module tb_alu_issue_arbiter;
  import alu_issue_arbiter_pkg::*;

  localparam int unsigned TAG_W = 4;
  localparam int unsigned DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             p0_valid, p0_aux, p0_rsp_ready, p1_valid, p1_aux, p1_rsp_ready;
  logic [31:0]      p0_a, p0_b, p1_a, p1_b;
  logic [2:0]       p0_op, p1_op;
  logic [TAG_W-1:0] p0_tag, p1_tag;

  logic             p0_ready, p1_ready, p0_rsp_valid, p1_rsp_valid, alu_aux;
  logic [31:0]      p0_rsp_result, p1_rsp_result, alu_a, alu_b, alu_result;
  logic [TAG_W-1:0] p0_rsp_tag, p1_rsp_tag;
  logic [2:0]       alu_op;

  logic             fp_p0_ready, fp_p1_ready, fp_p0_rsp_valid, fp_p1_rsp_valid, fp_alu_aux;
  logic [31:0]      fp_p0_rsp_result, fp_p1_rsp_result, fp_alu_a, fp_alu_b, fp_alu_result;
  logic [TAG_W-1:0] fp_p0_rsp_tag, fp_p1_rsp_tag;
  logic [2:0]       fp_alu_op;

  alu_issue_arbiter #(.TAG_W(TAG_W), .RSP_DEPTH(DEPTH), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_a(p0_a), .p0_b(p0_b), .p0_op(p0_op),
    .p0_aux(p0_aux), .p0_tag(p0_tag), .p0_rsp_valid(p0_rsp_valid),
    .p0_rsp_ready(p0_rsp_ready), .p0_rsp_result(p0_rsp_result), .p0_rsp_tag(p0_rsp_tag),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_a(p1_a), .p1_b(p1_b), .p1_op(p1_op),
    .p1_aux(p1_aux), .p1_tag(p1_tag), .p1_rsp_valid(p1_rsp_valid),
    .p1_rsp_ready(p1_rsp_ready), .p1_rsp_result(p1_rsp_result), .p1_rsp_tag(p1_rsp_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_aux(alu_aux),
    .alu_result(alu_result)
  );

  alu_issue_arbiter #(.TAG_W(TAG_W), .RSP_DEPTH(DEPTH), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_ready(fp_p0_ready), .p0_a(p0_a), .p0_b(p0_b), .p0_op(p0_op),
    .p0_aux(p0_aux), .p0_tag(p0_tag), .p0_rsp_valid(fp_p0_rsp_valid),
    .p0_rsp_ready(p0_rsp_ready), .p0_rsp_result(fp_p0_rsp_result),
    .p0_rsp_tag(fp_p0_rsp_tag),
    .p1_valid(p1_valid), .p1_ready(fp_p1_ready), .p1_a(p1_a), .p1_b(p1_b), .p1_op(p1_op),
    .p1_aux(p1_aux), .p1_tag(p1_tag), .p1_rsp_valid(fp_p1_rsp_valid),
    .p1_rsp_ready(p1_rsp_ready), .p1_rsp_result(fp_p1_rsp_result),
    .p1_rsp_tag(fp_p1_rsp_tag),
    .alu_a(fp_alu_a), .alu_b(fp_alu_b), .alu_op(fp_alu_op), .alu_aux(fp_alu_aux),
    .alu_result(fp_alu_result)
  );

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op, input logic aux);
    logic signed [31:0] sa;
    logic [31:0] r;
    sa = a;
    case (op)
      ALU_ADD:  r = aux ? a - b : a + b;
      ALU_SLL:  r = a << b[4:0];
      ALU_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
      ALU_XOR:  r = a ^ b;
      ALU_SRL: begin
        if (aux) r = sa >>> b[4:0];
        else     r = a >> b[4:0];
      end
      ALU_OR:   r = a | b;
      default:  r = a & b;
    endcase
    return r;
  endfunction

  // Registered ALU with one cycle of latency, one per DUT.
  always_ff @(posedge clk) begin
    alu_result    <= alu_ref(alu_a, alu_b, alu_op, alu_aux);
    fp_alu_result <= alu_ref(fp_alu_a, fp_alu_b, fp_alu_op, fp_alu_aux);
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic             s_rdy0, s_rdy1, s_rv0, s_rv1, s_fp_rdy0, s_fp_rdy1;
  logic [31:0]      s_res0, s_res1, s_alu_a;
  logic [TAG_W-1:0] s_tag0, s_tag1;

  task automatic tick();
    @(negedge clk);
    s_rdy0 = p0_ready;  s_rdy1 = p1_ready;
    s_rv0  = p0_rsp_valid;  s_rv1 = p1_rsp_valid;
    s_res0 = p0_rsp_result; s_res1 = p1_rsp_result;
    s_tag0 = p0_rsp_tag;    s_tag1 = p1_rsp_tag;
    s_alu_a = alu_a;
    s_fp_rdy0 = fp_p0_ready; s_fp_rdy1 = fp_p1_ready;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    p0_valid = 1'b0; p1_valid = 1'b0; p0_rsp_ready = 1'b1; p1_rsp_ready = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_p0(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        input logic aux, input logic [TAG_W-1:0] tag);
    p0_valid = 1'b1; p0_a = a; p0_b = b; p0_op = op; p0_aux = aux; p0_tag = tag;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    p0_valid = 1'b1; p1_valid = 1'b1; p0_a = 32'h1234; p1_a = 32'h5678;
    p0_rsp_ready = 1'b1; p1_rsp_ready = 1'b1;
    tick();
    checks++;
    if ({s_rdy0, s_rdy1, s_rv0, s_rv1} !== 4'b0000) begin
      errors++; $display("FAIL reset_outputs: got %b required 0000", {s_rdy0, s_rdy1, s_rv0, s_rv1});
    end
    checks++;
    if (s_alu_a !== 32'h0) begin errors++; $display("FAIL reset_alu_a: got %h required 0", s_alu_a); end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({s_rdy0, s_rdy1, s_rv0, s_rv1} !== 4'b0000) begin
      errors++; $display("FAIL post_reset_outputs: got %b required 0000", {s_rdy0, s_rdy1, s_rv0, s_rv1});
    end
    checks++;
    if (s_alu_a !== 32'h0) begin errors++; $display("FAIL post_reset_alu_a: got %h required 0", s_alu_a); end
    tick();
    checks++;
    if ({s_rdy0, s_rdy1} !== 2'b10) begin
      errors++; $display("FAIL reset_prio_port0: got %b required 10", {s_rdy0, s_rdy1});
    end
    checks++;
    if (s_alu_a !== 32'h1234) begin errors++; $display("FAIL reset_alu_drive: got %h required 1234", s_alu_a); end
    idle(4);
  endtask

  task automatic test_single_op();
    set_p0(32'd5, 32'd3, ALU_ADD, 1'b1, 4'd2);
    tick();
    checks++;
    if (s_rdy0 !== 1'b1) begin errors++; $display("FAIL single_accept: got %b required 1", s_rdy0); end
    p0_valid = 1'b0;
    tick();
    checks++;
    if ({s_rv0, s_rv1} !== 2'b00) begin errors++; $display("FAIL single_early: got %b required 00", {s_rv0, s_rv1}); end
    tick();
    checks++;
    if ({s_rv0, s_rv1, s_res0, s_tag0} !== {2'b10, 32'd2, 4'd2}) begin
      errors++; $display("FAIL single_result: got v=%b%b res=%h tag=%h required v=10 res=2 tag=2", s_rv0, s_rv1, s_res0, s_tag0);
    end
    tick();
    checks++;
    if ({s_rv0, s_rv1} !== 2'b00) begin errors++; $display("FAIL single_after: got %b required 00", {s_rv0, s_rv1}); end
    idle(2);
  endtask

  task automatic test_back_to_back();
    logic [31:0] ba [3];
    logic [31:0] bb [3];
    logic [2:0]  bo [3];
    logic        bx [3];
    logic [31:0] er [3];
    ba = '{32'd1, 32'h80000000, 32'hF0};
    bb = '{32'd4, 32'd4, 32'hFF};
    bo = '{ALU_SLL, ALU_SRL, ALU_XOR};
    bx = '{1'b0, 1'b1, 1'b0};
    er = '{32'h10, 32'hF8000000, 32'h0F};
    for (int i = 0; i < 6; i++) begin
      if (i < 3) begin
        p1_valid = 1'b1; p1_a = ba[i]; p1_b = bb[i]; p1_op = bo[i]; p1_aux = bx[i];
        p1_tag = TAG_W'(i + 1);
      end else begin
        p1_valid = 1'b0;
      end
      tick();
      if (i < 3) begin
        checks++;
        if (s_rdy1 !== 1'b1) begin errors++; $display("FAIL b2b_accept%0d: got %b required 1", i, s_rdy1); end
      end
      if (i >= 2 && i < 5) begin
        checks++;
        if ({s_rv1, s_res1, s_tag1} !== {1'b1, er[i-2], TAG_W'(i - 1)}) begin
          errors++; $display("FAIL b2b_result%0d: got v=%b res=%h tag=%h required v=1 res=%h tag=%h", i - 2, s_rv1, s_res1, s_tag1, er[i-2], i - 1);
        end
      end
      if (i == 5) begin
        checks++;
        if (s_rv1 !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b required 0", s_rv1); end
      end
    end
    idle(2);
  endtask

  task automatic test_contention();
    p0_op = ALU_OR; p1_op = ALU_OR; p0_aux = 1'b0; p1_aux = 1'b0;
    for (int i = 0; i < 6; i++) begin
      p0_valid = 1'b1; p1_valid = 1'b1;
      p0_a = 32'hA0 + 32'(i); p1_a = 32'hB0 + 32'(i);
      tick();
      checks++;
      if ({s_rdy0, s_rdy1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL rr_grant%0d: got %b required %b", i, {s_rdy0, s_rdy1}, (i % 2 == 0) ? 2'b10 : 2'b01);
      end
      checks++;
      if (s_alu_a !== ((i % 2 == 0) ? 32'hA0 + 32'(i) : 32'hB0 + 32'(i))) begin
        errors++; $display("FAIL rr_alu_a%0d: got %h required %h", i, s_alu_a, (i % 2 == 0) ? 32'hA0 + 32'(i) : 32'hB0 + 32'(i));
      end
      checks++;
      if ({s_fp_rdy0, s_fp_rdy1} !== 2'b10) begin
        errors++; $display("FAIL fixed_grant%0d: got %b required 10", i, {s_fp_rdy0, s_fp_rdy1});
      end
    end
    idle(4);
  endtask

  task automatic test_backpressure();
    int acc0 = 0;
    int acc1 = 0;
    p0_rsp_ready = 1'b0; p1_rsp_ready = 1'b1;
    p1_op = ALU_AND; p1_a = 32'hFF; p1_b = 32'h0F; p1_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_p0(32'd100 + 32'(i), 32'd1, ALU_ADD, 1'b0, TAG_W'(i));
      tick();
      if (s_rdy0) acc0++;
      if (s_rdy1) acc1++;
      checks++;
      if (s_rdy1 !== !s_rdy0) begin
        errors++; $display("FAIL bp_other_port%0d: got p1_ready=%b required %b", i, s_rdy1, !s_rdy0);
      end
      if (i >= 2) begin
        checks++;
        if ({s_rv0, s_res0, s_tag0} !== {1'b1, 32'd101, 4'd0}) begin
          errors++; $display("FAIL bp_hold%0d: got v=%b res=%h tag=%h required v=1 res=65 tag=0", i, s_rv0, s_res0, s_tag0);
        end
      end
    end
    checks++;
    if (acc0 != 2) begin errors++; $display("FAIL bp_accepts0: got %0d required 2", acc0); end
    checks++;
    if (acc1 != 6) begin errors++; $display("FAIL bp_accepts1: got %0d required 6", acc1); end
    p0_valid = 1'b0; p1_valid = 1'b0; p0_rsp_ready = 1'b1;
    tick();
    checks++;
    if ({s_rv0, s_res0, s_tag0} !== {1'b1, 32'd101, 4'd0}) begin
      errors++; $display("FAIL bp_drain0: got v=%b res=%h tag=%h required v=1 res=65 tag=0", s_rv0, s_res0, s_tag0);
    end
    tick();
    checks++;
    if ({s_rv0, s_res0, s_tag0} !== {1'b1, 32'd103, 4'd2}) begin
      errors++; $display("FAIL bp_drain1: got v=%b res=%h tag=%h required v=1 res=67 tag=2", s_rv0, s_res0, s_tag0);
    end
    tick();
    checks++;
    if (s_rv0 !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b required 0", s_rv0); end
    set_p0(32'd1, 32'd1, ALU_ADD, 1'b0, 4'd1);
    tick();
    checks++;
    if (s_rdy0 !== 1'b1) begin errors++; $display("FAIL bp_resume: got %b required 1", s_rdy0); end
    idle(4);
  endtask

  task automatic test_simultaneous();
    p0_rsp_ready = 1'b0;
    set_p0(32'hFFFFFFFF, 32'd1, ALU_SLT, 1'b0, 4'd5);
    tick();
    checks++;
    if (s_rdy0 !== 1'b1) begin errors++; $display("FAIL sim_accept_slt: got %b required 1", s_rdy0); end
    set_p0(32'hFFFFFFFF, 32'd1, ALU_SLTU, 1'b0, 4'd6);
    tick();
    checks++;
    if ({s_rdy0, s_rv0} !== 2'b10) begin errors++; $display("FAIL sim_accept_sltu: got %b required 10", {s_rdy0, s_rv0}); end
    p0_rsp_ready = 1'b1;
    set_p0(32'd7, 32'd8, ALU_ADD, 1'b0, 4'd7);
    tick();
    checks++;
    if ({s_rdy0, s_rv0, s_res0, s_tag0} !== {2'b11, 32'd1, 4'd5}) begin
      errors++; $display("FAIL sim_pop_and_grant: got rdy=%b v=%b res=%h tag=%h required rdy=1 v=1 res=1 tag=5", s_rdy0, s_rv0, s_res0, s_tag0);
    end
    p0_valid = 1'b0;
    tick();
    checks++;
    if ({s_rv0, s_res0, s_tag0} !== {1'b1, 32'd0, 4'd6}) begin
      errors++; $display("FAIL sim_sltu_result: got v=%b res=%h tag=%h required v=1 res=0 tag=6", s_rv0, s_res0, s_tag0);
    end
    tick();
    checks++;
    if ({s_rv0, s_res0, s_tag0} !== {1'b1, 32'd15, 4'd7}) begin
      errors++; $display("FAIL sim_add_result: got v=%b res=%h tag=%h required v=1 res=f tag=7", s_rv0, s_res0, s_tag0);
    end
    tick();
    checks++;
    if (s_rv0 !== 1'b0) begin errors++; $display("FAIL sim_no_duplicate: got %b required 0", s_rv0); end
    idle(2);
  endtask

  task automatic test_reset_midflight();
    set_p0(32'd1, 32'd1, ALU_ADD, 1'b0, 4'd9);
    tick();
    checks++;
    if (s_rdy0 !== 1'b1) begin errors++; $display("FAIL rmf_accept: got %b required 1", s_rdy0); end
    p0_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    set_p0(32'd10, 32'd20, ALU_ADD, 1'b0, 4'd3);
    tick();
    checks++;
    if ({s_rdy0, s_rv0} !== 2'b00) begin errors++; $display("FAIL rmf_hold: got %b required 00", {s_rdy0, s_rv0}); end
    tick();
    checks++;
    if ({s_rdy0, s_rv0} !== 2'b10) begin errors++; $display("FAIL rmf_new_accept: got %b required 10", {s_rdy0, s_rv0}); end
    p0_valid = 1'b0;
    tick();
    checks++;
    if (s_rv0 !== 1'b0) begin errors++; $display("FAIL rmf_stale: got %b required 0", s_rv0); end
    tick();
    checks++;
    if ({s_rv0, s_res0, s_tag0} !== {1'b1, 32'd30, 4'd3}) begin
      errors++; $display("FAIL rmf_result: got v=%b res=%h tag=%h required v=1 res=1e tag=3", s_rv0, s_res0, s_tag0);
    end
    tick();
    checks++;
    if (s_rv0 !== 1'b0) begin errors++; $display("FAIL rmf_after: got %b required 0", s_rv0); end
    idle(2);
  endtask

  typedef struct {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
    int               cyc;
  } exp_t;

  task automatic test_random();
    exp_t q0[$];
    exp_t q1[$];
    exp_t f0, f1;
    int   last;
    int   c;
    logic erv0, erv1, pop0, pop1, el0, el1, eg0, eg1;
    logic [31:0] ea;
    rst = 1'b1; p0_valid = 1'b0; p1_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    last = 1;
    for (int i = 0; i < 400; i++) begin
      p0_valid = ($urandom_range(3) != 0); p1_valid = ($urandom_range(3) != 0);
      p0_a = $urandom; p1_a = $urandom;
      p0_b = $urandom_range(1) ? $urandom : 32'($urandom_range(40));
      p1_b = $urandom_range(1) ? $urandom : 32'($urandom_range(40));
      p0_op = 3'($urandom_range(7)); p1_op = 3'($urandom_range(7));
      p0_aux = 1'($urandom_range(1)); p1_aux = 1'($urandom_range(1));
      p0_tag = TAG_W'($urandom_range(15)); p1_tag = TAG_W'($urandom_range(15));
      p0_rsp_ready = ($urandom_range(2) != 0); p1_rsp_ready = ($urandom_range(3) == 0);
      c = cyc;
      erv0 = 1'b0; erv1 = 1'b0;
      if (q0.size() > 0) begin f0 = q0[0]; erv0 = (c - f0.cyc >= 2); end
      if (q1.size() > 0) begin f1 = q1[0]; erv1 = (c - f1.cyc >= 2); end
      pop0 = erv0 && p0_rsp_ready;
      pop1 = erv1 && p1_rsp_ready;
      // Outstanding ops per port (accepted, not yet consumed) are the credits.
      el0 = p0_valid && (q0.size() < DEPTH || pop0);
      el1 = p1_valid && (q1.size() < DEPTH || pop1);
      eg0 = el0 && (!el1 || last == 1);
      eg1 = el1 && !eg0;
      ea = eg0 ? p0_a : (eg1 ? p1_a : 32'h0);
      tick();
      checks++;
      if ({s_rv0, s_rv1} !== {erv0, erv1}) begin
        errors++; $display("FAIL rnd_rsp_valid c%0d: got %b required %b", c, {s_rv0, s_rv1}, {erv0, erv1});
      end
      checks++;
      if ({s_rdy0, s_rdy1} !== {eg0, eg1}) begin
        errors++; $display("FAIL rnd_grant c%0d: got %b required %b", c, {s_rdy0, s_rdy1}, {eg0, eg1});
      end
      checks++;
      if (s_alu_a !== ea) begin errors++; $display("FAIL rnd_alu_a c%0d: got %h required %h", c, s_alu_a, ea); end
      if (pop0) begin
        checks++;
        if ({s_res0, s_tag0} !== {f0.res, f0.tag}) begin
          errors++; $display("FAIL rnd_rsp0 c%0d: got res=%h tag=%h required res=%h tag=%h", c, s_res0, s_tag0, f0.res, f0.tag);
        end
        void'(q0.pop_front());
      end
      if (pop1) begin
        checks++;
        if ({s_res1, s_tag1} !== {f1.res, f1.tag}) begin
          errors++; $display("FAIL rnd_rsp1 c%0d: got res=%h tag=%h required res=%h tag=%h", c, s_res1, s_tag1, f1.res, f1.tag);
        end
        void'(q1.pop_front());
      end
      if (eg0) begin
        q0.push_back('{res: alu_ref(p0_a, p0_b, p0_op, p0_aux), tag: p0_tag, cyc: c});
        last = 0;
      end
      if (eg1) begin
        q1.push_back('{res: alu_ref(p1_a, p1_b, p1_op, p1_aux), tag: p1_tag, cyc: c});
        last = 1;
      end
    end
    idle(4);
  endtask

  initial begin
    rst = 1'b1;
    p0_valid = 1'b0; p0_a = '0; p0_b = '0; p0_op = '0; p0_aux = 1'b0; p0_tag = '0;
    p1_valid = 1'b0; p1_a = '0; p1_b = '0; p1_op = '0; p1_aux = 1'b0; p1_tag = '0;
    p0_rsp_ready = 1'b1; p1_rsp_ready = 1'b1;
    test_reset();
    test_single_op();
    test_back_to_back();
    test_contention();
    test_backpressure();
    test_simultaneous();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
